// File: rtl/lut_word_streamer.sv
// lut_word_streamer: sequences bursts of reads from a 1-cycle registered ROM
// and presents the words in address order on a valid/ready stream.
module lut_word_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] lut_addr,
  input  logic [DATA_WIDTH-1:0] lut_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q;
  logic [ADDR_WIDTH:0]   count_q, count_d, issued_q, issued_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         rd_q, wr_q;
  logic [CW-1:0]         fill_q, fill_d;
  logic                  pop, issue;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign pop      = m_valid & m_ready;
  assign m_valid  = fill_q != '0;
  assign m_data   = m_valid ? mem_q[rd_q] : '0;
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  // a read is only issued if its word is guaranteed a buffer slot on arrival
  assign issue    = state_q == RUN && fill_q + CW'(inflight_q) < CW'(FIFO_DEPTH) + CW'(pop);
  assign fill_d   = fill_q + CW'(inflight_q) - CW'(pop);
  assign lut_addr = state_q == IDLE ? '0 : issue ? base_q + issued_q[ADDR_WIDTH-1:0] : addr_q;
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    count_d  = count_q;
    issued_d = issue ? issued_q + (ADDR_WIDTH+1)'(1) : issued_q;
    case (state_q)
      IDLE:
        if (start) begin
          base_d   = base_addr;
          count_d  = word_count;
          issued_d = '0;
          state_d  = word_count == '0 ? DONE : RUN;
        end
      RUN:     state_d = issued_d == count_q ? DRAIN : RUN;
      DRAIN:   state_d = fill_d == '0 ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      rd_q       <= '0;
      wr_q       <= '0;
      fill_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      addr_q     <= lut_addr;
      inflight_q <= issue;
      fill_q     <= fill_d;
      if (inflight_q) wr_q <= nxt(wr_q);
      if (pop) rd_q <= nxt(rd_q);
    end
  end
  always_ff @(posedge clk)
    if (rst && inflight_q) mem_q[wr_q] <= lut_data;
endmodule

// File: tb/tb_lut_word_streamer.sv
// tb_lut_word_streamer: directed bursts against a behavioural registered ROM.
module tb_lut_word_streamer;
  logic        clk = 0;
  logic        rst = 0;
  logic        start = 0;
  logic [4:0]  base_addr = 0;
  logic [5:0]  word_count = 0;
  logic        busy, done, m_valid;
  logic        m_ready = 1;
  logic [4:0]  lut_addr;
  logic [31:0] lut_data = 0;
  logic [31:0] m_data;
  int          n_vec = 0, n_err = 0;
  logic [31:0] words [64];
  int          wcyc [64];
  int          dcyc [8];
  logic [4:0]  alog [64];
  int          nw, nd, busy_fall, restart_at = -1;

  lut_word_streamer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .lut_addr(lut_addr), .lut_data(lut_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input int a);
    return 32'(a) * 32'h01010101;
  endfunction

  always_ff @(posedge clk) lut_data <= rom(int'(lut_addr));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic burst(input logic [4:0] b, input logic [5:0] c, input int ncyc);
    nw = 0;
    nd = 0;
    busy_fall = 0;
    base_addr = b;
    word_count = c;
    start = 1;
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      start = k == restart_at;
      if (k == restart_at) begin
        base_addr = 10;
        word_count = 3;
      end
      alog[k] = lut_addr;
      if (m_valid && nw < 64) begin
        words[nw] = m_data;
        wcyc[nw] = k;
        nw++;
      end
      if (done && nd < 8) begin
        dcyc[nd] = k;
        nd++;
      end
      if (!busy && busy_fall == 0) busy_fall = k;
    end
    start = 0;
    restart_at = -1;
  endtask

  initial begin
    int exp_i, stall_bad, early, nz, nvalid;
    logic prev_stall;
    logic [31:0] prev_data;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_addr", lut_addr, 0);
    rst = 1;
    tick();

    burst(3, 4, 10);
    check("t1_addr1", alog[1], 3);
    check("t1_nwords", nw, 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_word", words[i], rom(3 + i));
      check("t1_wcyc", wcyc[i], 3 + i);
    end
    check("t1_ndone", nd, 1);
    check("t1_done_cyc", dcyc[0], 7);
    check("t1_busy_fall", busy_fall, 8);

    burst(30, 4, 10);
    check("t2_addr1", alog[1], 30);
    check("t2_addr2", alog[2], 31);
    check("t2_addr3", alog[3], 0);
    check("t2_addr4", alog[4], 1);
    check("t2_nwords", nw, 4);
    check("t2_w0", words[0], rom(30));
    check("t2_w1", words[1], rom(31));
    check("t2_w2", words[2], rom(0));
    check("t2_w3", words[3], rom(1));

    burst(7, 0, 5);
    nz = 0;
    for (int k = 1; k <= 5; k++) if (alog[k] != 0) nz++;
    check("t3_addr_moved", nz, 0);
    check("t3_nwords", nw, 0);
    check("t3_ndone", nd, 1);
    check("t3_done_early", dcyc[0] >= 1 && dcyc[0] <= 2, 1);
    check("t3_busy_fall", busy_fall >= 2 && busy_fall <= 3, 1);

    base_addr = 0;
    word_count = 32;
    start = 1;
    m_ready = 0;
    tick();
    start = 0;
    exp_i = 0;
    nd = 0;
    early = 0;
    stall_bad = 0;
    prev_stall = 0;
    prev_data = 0;
    for (int k = 0; k < 600 && busy; k++) begin
      if (prev_stall && (!m_valid || m_data != prev_data)) stall_bad++;
      if (done) begin
        nd++;
        if (exp_i != 32) early++;
      end
      m_ready = 1'($urandom_range(0, 1));
      if (m_valid && m_ready) begin
        check("t4_word", m_data, rom(exp_i));
        exp_i++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      tick();
    end
    m_ready = 1;
    check("t4_nwords", exp_i, 32);
    check("t4_ndone", nd, 1);
    check("t4_early_done", early, 0);
    check("t4_stall_change", stall_bad, 0);
    check("t4_idle", busy, 0);

    base_addr = 0;
    word_count = 8;
    start = 1;
    tick();
    start = 0;
    repeat (4) tick();
    check("t5_w2", m_data, rom(2));
    tick();
    rst = 0;
    tick();
    rst = 1;
    check("t5_rst_valid", m_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_addr", lut_addr, 0);
    burst(0, 2, 10);
    check("t5_nwords", nw, 2);
    check("t5_w0", words[0], rom(0));
    check("t5_w1", words[1], rom(1));
    check("t5_ndone", nd, 1);

    restart_at = 2;
    burst(5, 6, 14);
    nvalid = 0;
    for (int i = 0; i < 6; i++) if (words[i] == rom(5 + i) && wcyc[i] == 3 + i) nvalid++;
    check("t6_nwords", nw, 6);
    check("t6_in_order", nvalid, 6);
    check("t6_done_cyc", dcyc[0], 9);
    check("t6_ndone", nd, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
